// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between ALU control/operand fetch and the execute-stage ALU.
// Master drives operations and accepts results; slave is the ALU.
interface alu_exec_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         operation;
  logic               jr_in;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               jr_out;
  logic               illegal_op;
  logic               busy;

  modport master (
    output in_valid, operation, jr_in, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, jr_out, illegal_op, busy
  );

  modport slave (
    input  in_valid, operation, jr_in, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero, jr_out, illegal_op, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS execute ALU: latency 1, sll shamt+1 (1 when ALU_BARREL_SHIFT_EN is defined).
// Result held until out_ready; in_ready is combinational and allows back-to-back accepts in DONE.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave io
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               jr_q, jr_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [SHAMT_W-1:0] count_q, count_d;

  logic               accept;
  logic               start_shift;
  logic               last_shift;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;
  logic [WIDTH-1:0]   shift_next;

  assign accept     = io.in_valid && io.in_ready;
  assign last_shift = (count_q == SHAMT_W'(1));
  assign shift_next = shift_q << 1;

`ifdef ALU_BARREL_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = (io.operation == OP_SLL) && (io.shamt != '0);
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (io.operation)
      OP_AND: alu_res = io.a & io.b;
      OP_OR:  alu_res = io.a | io.b;
      OP_ADD: alu_res = io.a + io.b;
      OP_SUB: alu_res = io.a - io.b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(io.a) < $signed(io.b))};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: alu_res = io.b << io.shamt;
`else
      // Only reached with shamt==0 here; nonzero shifts go through SHIFT.
      OP_SLL: alu_res = io.b;
`endif
      OP_NOR: alu_res = ~(io.a | io.b);
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

  // State register (plus datapath flops)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      jr_q      <= 1'b0;
      illegal_q <= 1'b0;
      shift_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      jr_q      <= jr_d;
      illegal_q <= illegal_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = start_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (last_shift) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (accept)             state_d = start_shift ? ST_SHIFT : ST_DONE;
        else if (io.out_ready)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    io.in_ready   = rst_n && ((state_q == ST_IDLE) ||
                              ((state_q == ST_DONE) && io.out_ready));
    io.out_valid  = (state_q == ST_DONE);
    io.busy       = (state_q == ST_SHIFT);
    io.result     = result_q;
    io.zero       = zero_q;
    io.jr_out     = jr_q;
    io.illegal_op = illegal_q;
  end

  // Datapath next values; result fields only change on accept or shift completion.
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    jr_d      = jr_q;
    illegal_d = illegal_q;
    shift_d   = shift_q;
    count_d   = count_q;
    if (accept) begin
      jr_d      = io.jr_in;
      illegal_d = alu_ill;
      if (start_shift) begin
        shift_d = io.b;
        count_d = io.shamt;
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
      end
    end else if (state_q == ST_SHIFT) begin
      shift_d = shift_next;
      count_d = count_q - SHAMT_W'(1);
      if (last_shift) begin
        result_d = shift_next;
        zero_d   = (shift_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expected values are hand-computed constants.
module tb_alu_exec_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int SLL4_LAT  = 1;
  localparam int SLL4_BUSY = 0;
  localparam logic SHIFT_BUSY = 1'b0;
`else
  localparam int SLL4_LAT  = 5;
  localparam int SLL4_BUSY = 4;
  localparam logic SHIFT_BUSY = 1'b1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] sh, input logic jr);
    bus.operation = op;
    bus.a         = aa;
    bus.b         = bb;
    bus.shamt     = sh;
    bus.jr_in     = jr;
    bus.in_valid  = 1'b1;
  endtask

  // Issue one op from IDLE, return cycles until out_valid and cycles seen busy.
  task automatic do_op(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] sh, input logic jr, output int lat, output int busy_cyc);
    drive(op, aa, bb, sh, jr);
    #1;
    check("acc_rdy", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat      = 1;
    busy_cyc = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_vld", {31'b0, bus.out_valid}, 32'd1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("vld_drop", {31'b0, bus.out_valid}, 32'd0);
  endtask

  logic [3:0]  b2b_op  [4];
  logic [31:0] b2b_a   [4];
  logic [31:0] b2b_b   [4];
  logic [31:0] b2b_exp [4];

  initial begin
    int lat;
    int bcyc;
    int seen;
    n_tests = 0;
    n_fail  = 0;

    b2b_op[0] = 4'b0000; b2b_a[0] = 32'hF0F0_F0F0; b2b_b[0] = 32'hFF00_FF00; b2b_exp[0] = 32'hF000_F000;
    b2b_op[1] = 4'b0001; b2b_a[1] = 32'h0F0F_0000; b2b_b[1] = 32'h0000_00F0; b2b_exp[1] = 32'h0F0F_00F0;
    b2b_op[2] = 4'b0010; b2b_a[2] = 32'h7FFF_FFFF; b2b_b[2] = 32'h0000_0001; b2b_exp[2] = 32'h8000_0000;
    b2b_op[3] = 4'b0110; b2b_a[3] = 32'h0000_0003; b2b_b[3] = 32'h0000_0005; b2b_exp[3] = 32'hFFFF_FFFE;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operation = 4'b0;
    bus.jr_in     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.shamt     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld",  {31'b0, bus.out_valid},  32'd0);
    check("rst_res",  bus.result,              32'd0);
    check("rst_zero", {31'b0, bus.zero},       32'd0);
    check("rst_busy", {31'b0, bus.busy},       32'd0);
    check("rst_jr",   {31'b0, bus.jr_out},     32'd0);
    check("rst_ill",  {31'b0, bus.illegal_op}, 32'd0);
    check("rst_rdy",  {31'b0, bus.in_ready},   32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_rdy",  {31'b0, bus.in_ready},   32'd1);

    // add, then stall the consumer and disturb the inputs
    do_op(4'b0010, 32'h5, 32'h3, 5'd0, 1'b0, lat, bcyc);
    check("add_lat",  lat,                32'd1);
    check("add_res",  bus.result,         32'h8);
    check("add_zero", {31'b0, bus.zero},  32'd0);
    bus.a = 32'hFF;
    bus.operation = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_vld", {31'b0, bus.out_valid}, 32'd1);
      check("hold_res", bus.result,             32'h8);
    end
    consume();

    do_op(4'b0110, 32'h1234, 32'h1234, 5'd0, 1'b0, lat, bcyc);
    check("sub_res",  bus.result,        32'h0);
    check("sub_zero", {31'b0, bus.zero}, 32'd1);
    consume();
    do_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0, lat, bcyc);
    check("slt_neg",  bus.result,        32'h1);
    consume();
    do_op(4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0, 1'b0, lat, bcyc);
    check("slt_pos",  bus.result,        32'h0);
    consume();
    do_op(4'b1011, 32'h0, 32'h0, 5'd0, 1'b0, lat, bcyc);
    check("nor_res",  bus.result,        32'hFFFF_FFFF);
    check("nor_zero", {31'b0, bus.zero}, 32'd0);
    consume();
    do_op(4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0, lat, bcyc);
    check("add_wrap", bus.result,        32'h0);
    consume();

    do_op(4'b0101, 32'h0, 32'h1, 5'd4, 1'b0, lat, bcyc);
    check("sll_lat",  lat,        SLL4_LAT);
    check("sll_busy", bcyc,       SLL4_BUSY);
    check("sll_res",  bus.result, 32'h10);
    consume();
    do_op(4'b0101, 32'h0, 32'h0000_ABCD, 5'd0, 1'b0, lat, bcyc);
    check("sll0_lat", lat,        32'd1);
    check("sll0_res", bus.result, 32'h0000_ABCD);
    consume();
    do_op(4'b0101, 32'h0, 32'h8000_0001, 5'd1, 1'b0, lat, bcyc);
    check("sll1_res", bus.result, 32'h0000_0002);
    consume();

    // back-to-back stream with consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(b2b_op[i], b2b_a[i], b2b_b[i], 5'd0, 1'b0);
      #1;
      check("b2b_rdy", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("b2b_vld", {31'b0, bus.out_valid}, 32'd1);
      check("b2b_res", bus.result,             b2b_exp[i]);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_end", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    do_op(4'b0011, 32'h1, 32'h2, 5'd0, 1'b0, lat, bcyc);
    check("ill_flag", {31'b0, bus.illegal_op}, 32'd1);
    check("ill_res",  bus.result,              32'h0);
    consume();
    do_op(4'b0010, 32'h0040_0020, 32'h0, 5'd0, 1'b1, lat, bcyc);
    check("jr_out",   {31'b0, bus.jr_out},     32'd1);
    check("jr_res",   bus.result,              32'h0040_0020);
    check("jr_ill",   {31'b0, bus.illegal_op}, 32'd0);
    consume();

    // reset in the middle of a long shift
    drive(4'b0101, 32'h0, 32'h1, 5'd31, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", {31'b0, bus.busy}, {31'b0, SHIFT_BUSY});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mr_vld",  {31'b0, bus.out_valid}, 32'd0);
    check("mr_busy", {31'b0, bus.busy},      32'd0);
    check("mr_res",  bus.result,             32'd0);
    check("mr_rdy",  {31'b0, bus.in_ready},  32'd0);
    rst_n = 1'b1;
    #1;
    check("mr_rel",  {31'b0, bus.in_ready},  32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("no_ghost", seen, 32'd0);
    do_op(4'b0010, 32'h1, 32'h1, 5'd0, 1'b0, lat, bcyc);
    check("post_res", bus.result, 32'h2);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
